// File: rtl/ssram_bus_master.sv
// rtl/ssram_bus_master.sv - valid/ready command to ssram one-hot row/column bus initiator
// Optional write readback verify: define SSRAM_MASTER_READBACK_EN.
module ssram_bus_master #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [7:0]       cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_oor,
  output logic             rsp_err,
  output logic [15:0]      bus_row,
  output logic [15:0]      bus_col,
  output logic             bus_we,
  output logic             bus_re,
  inout  wire  [WIDTH-1:0] bus_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
`ifdef SSRAM_MASTER_READBACK_EN
    S_RB_SETUP,
    S_RB_STROBE,
`endif
    S_RESP
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t           r_state;
  logic             r_cmd_ready;
  logic             r_we;
  logic             r_oor;
  logic [WIDTH-1:0] r_wdata;
  logic             r_drive;
  logic [15:0]      r_bus_row;
  logic [15:0]      r_bus_col;
  logic             r_bus_we;
  logic             r_bus_re;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_rdata;
  logic             r_rsp_oor;
`ifdef SSRAM_MASTER_READBACK_EN
  logic             r_rsp_err;
`endif

  logic             w_hs;
  logic             w_oor;
  logic [15:0]      w_row;
  logic [15:0]      w_col;

  assign w_hs  = cmd_valid & r_cmd_ready;
  assign w_oor = ({1'b0, cmd_addr} >= DEPTH_L);
  assign w_row = w_oor ? 16'h0000 : (16'h0001 << cmd_addr[7:4]);
  assign w_col = w_oor ? 16'h0000 : (16'h0001 << cmd_addr[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_wdata     <= '0;
      r_drive     <= 1'b0;
      r_bus_row   <= '0;
      r_bus_col   <= '0;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_oor   <= 1'b0;
`ifdef SSRAM_MASTER_READBACK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_hs) begin
            r_cmd_ready <= 1'b0;
            r_we        <= cmd_we;
            r_oor       <= w_oor;
            r_wdata     <= cmd_wdata;
            r_bus_row   <= w_row;
            r_bus_col   <= w_col;
            // Write data goes out one cycle ahead of the strobe as bus turnaround.
            r_drive     <= cmd_we & ~w_oor;
            r_state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_bus_we <= r_we & ~r_oor;
          r_bus_re <= ~r_we & ~r_oor;
          r_state  <= S_STROBE;
        end
        S_STROBE: begin
          r_bus_we <= 1'b0;
          r_bus_re <= 1'b0;
          r_drive  <= 1'b0;
`ifdef SSRAM_MASTER_READBACK_EN
          if (r_we && !r_oor) begin
            r_state <= S_RB_SETUP;
          end else begin
            r_rsp_err <= 1'b0;
`else
          begin
`endif
            r_bus_row   <= '0;
            r_bus_col   <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_oor   <= r_oor;
            r_rsp_rdata <= (!r_we && !r_oor) ? bus_data : '0;
            r_state     <= S_RESP;
          end
        end
`ifdef SSRAM_MASTER_READBACK_EN
        S_RB_SETUP: begin
          r_bus_re <= 1'b1;
          r_state  <= S_RB_STROBE;
        end
        S_RB_STROBE: begin
          r_bus_re    <= 1'b0;
          r_bus_row   <= '0;
          r_bus_col   <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_oor   <= 1'b0;
          r_rsp_rdata <= '0;
          r_rsp_err   <= (bus_data != r_wdata);
          r_state     <= S_RESP;
        end
`endif
        S_RESP: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_bus_row   <= '0;
          r_bus_col   <= '0;
          r_bus_we    <= 1'b0;
          r_bus_re    <= 1'b0;
          r_drive     <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_data  = r_drive ? r_wdata : {WIDTH{1'bz}};
  assign cmd_ready = r_cmd_ready;
  assign bus_row   = r_bus_row;
  assign bus_col   = r_bus_col;
  assign bus_we    = r_bus_we;
  assign bus_re    = r_bus_re;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_oor   = r_rsp_oor;
`ifdef SSRAM_MASTER_READBACK_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ssram_bus_master.sv
// tb/tb_ssram_bus_master.sv - scoreboard bench for ssram_bus_master with a one-hot register array model
`timescale 1ns/1ps
module tb_ssram_bus_master;
  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
`ifdef SSRAM_MASTER_READBACK_EN
  localparam int WR_LAT = 5;
`else
  localparam int WR_LAT = 3;
`endif
  localparam logic [7:0] STUCK_ADDR = 8'h11;

  typedef struct {
    logic [15:0] rdata;
    logic        oor;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_oor, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] bus_row, bus_col;
  logic        bus_we, bus_re;
  wire  [15:0] bus_data;

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t m_e;
  logic [15:0] mem [256];
  logic [7:0]  m_idx;

  ssram_bus_master #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_oor(rsp_oor), .rsp_err(rsp_err),
    .bus_row(bus_row), .bus_col(bus_col), .bus_we(bus_we), .bus_re(bus_re),
    .bus_data(bus_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] enc(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Register array: target drives the bus combinationally while re is high.
  assign m_idx    = {enc(bus_row), enc(bus_col)};
  assign bus_data = bus_re ? mem[m_idx] : 16'hzzzz;
  always @(posedge clk)
    if (bus_we) mem[m_idx] <= (m_idx == STUCK_ADDR) ? (bus_data & ~16'h0008) : bus_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (t=%0t)", $time);
      end else begin
        m_e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_e.rdata));
        chk("rsp_oor", 32'(rsp_oor), 32'(m_e.oor));
        chk("rsp_err", 32'(rsp_err), 32'(m_e.err));
        chk("rsp_cycle", 32'(cyc), 32'(m_e.cyc));
      end
    end
    if (!rst && (bus_row != 16'h0 || bus_col != 16'h0)) begin
      chk("row_onehot", 32'($onehot(bus_row)), 32'd1);
      chk("col_onehot", 32'($onehot(bus_col)), 32'd1);
    end
  end

  task automatic send(input logic we, input logic [7:0] addr, input logic [15:0] wd,
                      input logic [15:0] erd, input logic eoor, input logic eerr,
                      input logic push, output int acc);
    exp_t e;
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wd;
    t = 0;
    while (!cmd_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    acc = cyc;
    if (push) begin
      e.rdata = erd;
      e.oor   = eoor;
      e.err   = eerr;
      e.cyc   = cyc + ((we && !eoor) ? WR_LAT : 3);
      exp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drop();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = 8'h0;
    cmd_wdata = 16'h0;

    #3;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_selects", {bus_row, bus_col}, 32'd0);
    chk("reset_strobes", {30'd0, bus_we, bus_re}, 32'd0);
    chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Write 0x23 <- A5A5: row 2, column 3.
    send(1'b1, 8'h23, 16'hA5A5, 16'h0, 1'b0, 1'b0, 1'b1, a0);
    drop();
    chk("setup_row", 32'(bus_row), 32'h0004);
    chk("setup_col", 32'(bus_col), 32'h0008);
    chk("setup_no_strobe", {30'd0, bus_we, bus_re}, 32'd0);
    chk("setup_wdata", 32'(bus_data), 32'hA5A5);
    chk("busy_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("strobe_we", {30'd0, bus_we, bus_re}, 32'd2);
    chk("strobe_wdata", 32'(bus_data), 32'hA5A5);
    @(negedge clk);
    chk("array_written", 32'(mem[8'h23]), 32'hA5A5);
    chk("we_dropped", 32'(bus_we), 32'd0);

    send(1'b1, 8'h24, 16'h0F0F, 16'h0, 1'b0, 1'b0, 1'b1, a0);
    drop();

    // Read 0x23 with a different wdata on the command to expose any stray master drive.
    send(1'b0, 8'h23, 16'hFFFF, 16'hA5A5, 1'b0, 1'b0, 1'b1, a0);
    drop();
    chk("rd_setup_no_re", {30'd0, bus_we, bus_re}, 32'd0);
    @(negedge clk);
    chk("rd_strobe_re", {30'd0, bus_we, bus_re}, 32'd1);
    chk("rd_strobe_data", 32'(bus_data), 32'hA5A5);
    @(negedge clk);
    chk("rd_resp_re_low", 32'(bus_re), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rsp_rdata_hold", 32'(rsp_rdata), 32'hA5A5);

    // Range boundary: 0x3F is the last implemented register, 0x40 the first missing one.
    send(1'b1, 8'h3F, 16'h5AC3, 16'h0, 1'b0, 1'b0, 1'b1, a0);
    drop();
    send(1'b0, 8'h3F, 16'h0, 16'h5AC3, 1'b0, 1'b0, 1'b1, a0);
    drop();
    send(1'b0, 8'h40, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, a0);
    drop();
    for (int i = 0; i < 3; i++) begin
      chk("oor_rd_quiet", {bus_row, bus_col}, 32'd0);
      chk("oor_rd_no_strobe", {30'd0, bus_we, bus_re}, 32'd0);
      if (i < 2) @(negedge clk);
    end
    send(1'b1, 8'hFF, 16'h5555, 16'h0, 1'b1, 1'b0, 1'b1, a0);
    drop();
    @(negedge clk);
    chk("oor_wr_no_strobe", {30'd0, bus_we, bus_re}, 32'd0);

    // Back-to-back with cmd_valid held high.
    send(1'b1, 8'h05, 16'h1111, 16'h0, 1'b0, 1'b0, 1'b1, a0);
    send(1'b1, 8'h30, 16'h2222, 16'h0, 1'b0, 1'b0, 1'b1, a1);
    send(1'b1, 8'h10, 16'h3333, 16'h0, 1'b0, 1'b0, 1'b1, a2);
    drop();
    chk("b2b_wr_gap1", 32'(a1 - a0), 32'(WR_LAT + 1));
    chk("b2b_wr_gap2", 32'(a2 - a1), 32'(WR_LAT + 1));
    send(1'b0, 8'h05, 16'h0, 16'h1111, 1'b0, 1'b0, 1'b1, a0);
    send(1'b0, 8'h30, 16'h0, 16'h2222, 1'b0, 1'b0, 1'b1, a1);
    send(1'b0, 8'h10, 16'h0, 16'h3333, 1'b0, 1'b0, 1'b1, a2);
    drop();
    chk("b2b_rd_gap1", 32'(a1 - a0), 32'd4);
    chk("b2b_rd_gap2", 32'(a2 - a1), 32'd4);

`ifdef SSRAM_MASTER_READBACK_EN
    // Register 0x11 has data bit 3 stuck at 0.
    send(1'b1, STUCK_ADDR, 16'h1238, 16'h0, 1'b0, 1'b1, 1'b1, a0);
    drop();
    send(1'b1, 8'h12, 16'h1238, 16'h0, 1'b0, 1'b0, 1'b1, a0);
    drop();
    send(1'b0, STUCK_ADDR, 16'h0, 16'h1230, 1'b0, 1'b0, 1'b1, a0);
    drop();
    send(1'b1, 8'h80, 16'h1238, 16'h0, 1'b1, 1'b0, 1'b1, a0);
    drop();
`endif

    // Reset in the middle of a write strobe: dropped, no response expected.
    send(1'b1, 8'h31, 16'hBEEF, 16'h0, 1'b0, 1'b0, 1'b0, a0);
    drop();
    @(negedge clk);
    chk("pre_reset_we", 32'(bus_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(bus_we), 32'd0);
    chk("async_rst_selects", {bus_row, bus_col}, 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("post_reset_ready", 32'(cmd_ready), 32'd1);
    send(1'b0, 8'h23, 16'h0, 16'hA5A5, 1'b0, 1'b0, 1'b1, a0);
    drop();

    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
